window_scan_ctrl: RTL and testbench

- Sequences the classifier over the frame buffer once the detection state machine asserts detect_en.
- Steps a WIN x WIN window across the IMG_W x IMG_H image in STEP-pixel strides and issues one frame-buffer read address per cycle; the address feeds the classifier read-address input of the buffer mux.
- Tags returning pixels with pix_valid, pix_first and pix_last after the memory latency.
- Collects the classifier verdict per window, reports hit coordinates and pulses detect_done at end of frame.

---
 rtl/window_scan_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_window_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_scan_ctrl.sv
// Window scan controller: steps a WIN x WIN window over the frame buffer, tags returning pixels
// and collects classifier verdicts. Optional macro EARLY_REJECT_EN enables cascade early exit.
module window_scan_ctrl #(
   parameter int IMG_W  = 160,
   parameter int IMG_H  = 120,
   parameter int WIN    = 24,
   parameter int STEP   = 4,
   parameter int RD_LAT = 2,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              detect_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              pix_valid,
   output logic              pix_first,
   output logic              pix_last,
   input  logic              cls_done,
   input  logic              cls_face,
   output logic              face_valid,
   output logic [7:0]        face_x,
   output logic [6:0]        face_y,
   output logic [9:0]        face_count,
   output logic              busy,
   output logic              detect_done
);
   localparam int                CW        = $clog2(WIN);
   localparam logic [CW-1:0]     WIN_LAST  = CW'(WIN - 1);
   localparam logic [8:0]        X_LIM     = 9'(IMG_W - WIN);
   localparam logic [7:0]        Y_LIM     = 8'(IMG_H - WIN);
   localparam logic [ADDR_W-1:0] ROW_INC   = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] YSTEP_INC = ADDR_W'(IMG_W * STEP);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      WAIT_CLS = 3'd2,
      NEXT     = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t            state_r, state_s;
   logic [CW-1:0]     row_r, col_r;
   logic [ADDR_W-1:0] row_base_r, y_base_r, rd_addr_r;
   logic [7:0]        win_x_r, face_x_r;
   logic [6:0]        win_y_r, face_y_r;
   logic [9:0]        face_count_r;
   logic              issue_r, first_r, last_r;
   logic              face_valid_r, detect_done_r, busy_r;
   logic [2:0]        dly_r [RD_LAT];
   logic              issue_s, flush_s, start_s, verdict_s;
   logic              first_pix_s, last_pix_s, x_more_s, y_more_s;

   assign first_pix_s = (row_r == '0) && (col_r == '0);
   assign last_pix_s  = (row_r == WIN_LAST) && (col_r == WIN_LAST);
   assign x_more_s    = ({1'b0, win_x_r} + 9'(STEP)) <= X_LIM;
   assign y_more_s    = ({1'b0, win_y_r} + 8'(STEP)) <= Y_LIM;

   // Next-state decode and per-cycle control strobes
   always_comb begin
      state_s   = state_r;
      issue_s   = 1'b0;
      flush_s   = 1'b0;
      start_s   = 1'b0;
      verdict_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (detect_en) begin
               state_s = FETCH;
               start_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         FETCH: begin
            if (!detect_en) begin
               state_s = IDLE;
               flush_s = 1'b1;
`ifdef EARLY_REJECT_EN
            end else if (cls_done && !cls_face) begin
               state_s = NEXT;
               flush_s = 1'b1;
`endif
            end else begin
               issue_s = 1'b1;
               if (last_pix_s) begin
                  state_s = WAIT_CLS;
               end else begin
                  state_s = FETCH;
               end
            end
         end
         WAIT_CLS: begin
            if (!detect_en) begin
               state_s = IDLE;
               flush_s = 1'b1;
            end else if (cls_done) begin
               state_s   = NEXT;
               verdict_s = 1'b1;
            end else begin
               state_s = WAIT_CLS;
            end
         end
         NEXT: begin
            if (!detect_en) begin
               state_s = IDLE;
               flush_s = 1'b1;
            end else if (x_more_s || y_more_s) begin
               state_s = FETCH;
            end else begin
               state_s = DONE;
            end
         end
         DONE: begin
            if (!detect_en) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
            flush_s = 1'b1;
         end
      endcase
   end

   // State, address walk, window origin and verdict bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         busy_r        <= 1'b0;
         detect_done_r <= 1'b0;
         face_valid_r  <= 1'b0;
         issue_r       <= 1'b0;
         first_r       <= 1'b0;
         last_r        <= 1'b0;
         rd_addr_r     <= '0;
         row_r         <= '0;
         col_r         <= '0;
         row_base_r    <= '0;
         y_base_r      <= '0;
         win_x_r       <= 8'd0;
         win_y_r       <= 7'd0;
         face_x_r      <= 8'd0;
         face_y_r      <= 7'd0;
         face_count_r  <= 10'd0;
      end else begin
         state_r       <= state_s;
         busy_r        <= (state_s != IDLE);
         detect_done_r <= (state_r == NEXT) && (state_s == DONE);
         face_valid_r  <= verdict_s & cls_face;
         issue_r       <= issue_s;
         first_r       <= issue_s & first_pix_s;
         last_r        <= issue_s & last_pix_s;
         if (issue_s) begin
            rd_addr_r <= y_base_r + row_base_r + ADDR_W'(win_x_r) + ADDR_W'(col_r);
         end
         if (start_s) begin
            win_x_r      <= 8'd0;
            win_y_r      <= 7'd0;
            y_base_r     <= '0;
            row_r        <= '0;
            col_r        <= '0;
            row_base_r   <= '0;
            face_count_r <= 10'd0;
         end else if (issue_s) begin
            // row_base advances by one image row per window row: additions only
            if (col_r == WIN_LAST) begin
               col_r      <= '0;
               row_r      <= row_r + CW'(1);
               row_base_r <= row_base_r + ROW_INC;
            end else begin
               col_r <= col_r + CW'(1);
            end
         end else if (state_r == NEXT) begin
            row_r      <= '0;
            col_r      <= '0;
            row_base_r <= '0;
            if (x_more_s) begin
               win_x_r <= win_x_r + 8'(STEP);
            end else begin
               win_x_r <= 8'd0;
               if (y_more_s) begin
                  win_y_r  <= win_y_r + 7'(STEP);
                  y_base_r <= y_base_r + YSTEP_INC;
               end
            end
         end else if (verdict_s && cls_face) begin
            face_x_r <= win_x_r;
            face_y_r <= win_y_r;
            if (face_count_r != 10'h3ff) begin
               face_count_r <= face_count_r + 10'd1;
            end
         end
      end
   end

   // Pixel tag delay line matching the frame-buffer read latency
   always_ff @(posedge clk) begin
      if (rst || flush_s) begin
         for (int k = 0; k < RD_LAT; k++) dly_r[k] <= 3'b000;
      end else begin
         dly_r[0] <= {issue_r, first_r, last_r};
         for (int k = 1; k < RD_LAT; k++) dly_r[k] <= dly_r[k-1];
      end
   end

   assign rd_addr     = rd_addr_r;
   assign pix_valid   = dly_r[RD_LAT-1][2];
   assign pix_first   = dly_r[RD_LAT-1][1];
   assign pix_last    = dly_r[RD_LAT-1][0];
   assign face_valid  = face_valid_r;
   assign face_x      = face_x_r;
   assign face_y      = face_y_r;
   assign face_count  = face_count_r;
   assign busy        = busy_r;
   assign detect_done = detect_done_r;
endmodule

// File: tb/tb_window_scan_ctrl.sv
// Self-checking bench for window_scan_ctrl: full scans against a queue-based address/verdict model.
module tb_window_scan_ctrl;
   localparam int W    = 42;
   localparam int H    = 30;
   localparam int N    = 8;
   localparam int S    = 4;
   localparam int L    = 2;
   localparam int AW   = 15;
   localparam int NX   = (W - N) / S + 1;
   localparam int NY   = (H - N) / S + 1;
   localparam int NWIN = NX * NY;

   typedef struct { int addr; bit first; bit last; } pix_t;
   typedef struct { int x; int y; } face_t;
   typedef struct { int win; int exp_first; int exp_last; } vec_t;

   logic          clk, rst, detect_en, cls_done, cls_face;
   logic [AW-1:0] rd_addr;
   logic          pix_valid, pix_first, pix_last, face_valid, busy, detect_done;
   logic [7:0]    face_x;
   logic [6:0]    face_y;
   logic [9:0]    face_count;

   int    tests = 0, failed = 0;
   int    addr_d1 = 0, addr_d2 = 0, done_cnt = 0, wi = 0, faces_exp = 0;
   bit    chk_pix = 1'b1;
   pix_t  exp_pix[$];
   face_t exp_face[$];
   bit    face_tbl [NWIN];
   int    win_first_a [NWIN];
   int    win_last_a [NWIN];
   vec_t  vecs [5];

   window_scan_ctrl #(.IMG_W(W), .IMG_H(H), .WIN(N), .STEP(S), .RD_LAT(L), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .detect_en(detect_en), .rd_addr(rd_addr),
      .pix_valid(pix_valid), .pix_first(pix_first), .pix_last(pix_last),
      .cls_done(cls_done), .cls_face(cls_face), .face_valid(face_valid),
      .face_x(face_x), .face_y(face_y), .face_count(face_count),
      .busy(busy), .detect_done(detect_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, failed=%0d", failed);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp_v);
      tests++;
      if (act != exp_v) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // One clock: sample at the falling edge and compare against the model queues
   task automatic step();
      pix_t  p;
      face_t f;
      @(negedge clk);
      if (pix_valid && chk_pix) begin
         if (exp_pix.size() == 0) begin
            chk("stray_pix_valid", 1, 0);
         end else begin
            p = exp_pix.pop_front();
            chk("pix_addr", addr_d2, p.addr);
            chk("pix_first", int'(pix_first), int'(p.first));
            chk("pix_last", int'(pix_last), int'(p.last));
         end
      end
      if (face_valid) begin
         if (exp_face.size() == 0) begin
            chk("stray_face_valid", 1, 0);
         end else begin
            f = exp_face.pop_front();
            chk("face_x", int'(face_x), f.x);
            chk("face_y", int'(face_y), f.y);
         end
      end
      if (detect_done) done_cnt++;
      if (pix_valid && pix_first && wi < NWIN) win_first_a[wi] = addr_d2;
      if (pix_valid && pix_last && wi < NWIN) begin
         win_last_a[wi] = addr_d2;
         wi++;
      end
      addr_d2 = addr_d1;
      addr_d1 = int'(rd_addr);
   endtask

   task automatic wait_pix(input bit want_last, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         step();
         if (pix_valid && (want_last ? pix_last : pix_first)) ok = 1'b1;
      end
      if (!ok) chk(want_last ? "timeout_pix_last" : "timeout_pix_first", 0, 1);
   endtask

   // mode 0: no faces, 1: faces on windows 1 and NX+1, 2: random verdicts and stray cls_done
   task automatic run_scan(input int mode, input int abort_win);
      bit ok;
      int ox, oy;
      exp_pix.delete();
      exp_face.delete();
      faces_exp = 0;
      done_cnt  = 0;
      wi        = 0;
      for (int w = 0; w < NWIN; w++) begin
         ox = (w % NX) * S;
         oy = (w / NX) * S;
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               exp_pix.push_back('{(oy + r) * W + ox + c, (r == 0 && c == 0), (r == N-1 && c == N-1)});
         face_tbl[w] = (mode == 1) ? (w == 0 || w == NX) :
                       (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (face_tbl[w]) begin
            exp_face.push_back('{ox, oy});
            faces_exp++;
         end
      end
      detect_en = 1'b1;
      for (int w = 0; w < NWIN; w++) begin
         wait_pix(1'b0, ok);
         if (!ok) return;
         if (w == abort_win - 1) begin
            repeat (3) step();
            detect_en = 1'b0;
            exp_pix.delete();
            exp_face.delete();
            step();
            chk("abort_busy", int'(busy), 0);
            repeat (4 * N * N) step();
            chk("abort_no_done", done_cnt, 0);
            return;
         end
         if (mode == 2 && $urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, N)) step();
            cls_done = 1'b1;
            cls_face = 1'b1;
            step();
            cls_done = 1'b0;
            cls_face = 1'b0;
         end
         wait_pix(1'b1, ok);
         if (!ok) return;
         repeat ($urandom_range(0, 3)) step();
         cls_done = 1'b1;
         cls_face = face_tbl[w];
         step();
         cls_done = 1'b0;
         cls_face = 1'b0;
      end
      for (int i = 0; i < 8 && done_cnt == 0; i++) step();
      chk("detect_done", done_cnt, 1);
      chk("face_count", int'(face_count), faces_exp);
      chk("pix_left", exp_pix.size(), 0);
      chk("face_left", exp_face.size(), 0);
      chk("win_count", wi, NWIN);
   endtask

`ifdef EARLY_REJECT_EN
   task automatic er_test();
      bit ok, seen_next, seen_last;
      chk_pix = 1'b0;
      exp_pix.delete();
      detect_en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         step();
         if (rd_addr == 15'd9) ok = 1'b1;
      end
      chk("er_addr9", int'(ok), 1);
      cls_done = 1'b1;
      cls_face = 1'b0;
      step();
      cls_done  = 1'b0;
      seen_next = 1'b0;
      seen_last = pix_valid & pix_last;
      for (int i = 0; i < 3; i++) begin
         step();
         if (int'(rd_addr) == S) seen_next = 1'b1;
         if (pix_valid && pix_last) seen_last = 1'b1;
      end
      for (int i = 0; i < 6; i++) begin
         step();
         if (pix_valid && pix_last) seen_last = 1'b1;
      end
      chk("er_next_window", int'(seen_next), 1);
      chk("er_no_pix_last", int'(seen_last), 0);
      detect_en = 1'b0;
      repeat (3) step();
      chk_pix = 1'b1;
   endtask
`endif

   initial begin
      vecs[0] = '{1, 0, 7 * W + 7};
      vecs[1] = '{2, S, 7 * W + S + 7};
      vecs[2] = '{NX, (NX - 1) * S, 7 * W + (NX - 1) * S + 7};
      vecs[3] = '{NX + 1, S * W, (S + 7) * W + 7};
      vecs[4] = '{NWIN, (NY - 1) * S * W + (NX - 1) * S, ((NY - 1) * S + 7) * W + (NX - 1) * S + 7};

      rst = 1'b1;
      detect_en = 1'b0;
      cls_done = 1'b0;
      cls_face = 1'b0;
      repeat (3) step();
      chk("rst_rd_addr", int'(rd_addr), 0);
      chk("rst_pix_valid", int'(pix_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_face_count", int'(face_count), 0);
      chk("rst_detect_done", int'(detect_done), 0);
      chk("rst_face_valid", int'(face_valid), 0);
      rst = 1'b0;
      repeat (2) step();

      run_scan(1, 0);
      repeat (20) step();
      chk("done_hold_single_pulse", done_cnt, 1);
      chk("done_hold_busy", int'(busy), 1);
      detect_en = 1'b0;
      repeat (2) step();
      chk("idle_busy", int'(busy), 0);
      chk("face_count_held", int'(face_count), 2);

      run_scan(0, 0);
      for (int i = 0; i < 5; i++) begin
         chk("win_first_addr", win_first_a[vecs[i].win - 1], vecs[i].exp_first);
         chk("win_last_addr", win_last_a[vecs[i].win - 1], vecs[i].exp_last);
      end
      detect_en = 1'b0;
      repeat (2) step();

      run_scan(0, 3);
      repeat (2) step();
      run_scan(2, 0);
      detect_en = 1'b0;
      repeat (3) step();
`ifdef EARLY_REJECT_EN
      er_test();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
